// File: rtl/pool_wb_pkg.sv
// pool_wb_pkg: hist tag encodings, FSM state type and saturating add shared by the writeback block
package pool_wb_pkg;
  localparam logic [1:0] HIST_FIRST  = 2'b00;
  localparam logic [1:0] HIST_MID    = 2'b01;
  localparam logic [1:0] HIST_LAST   = 2'b10;
  localparam logic [1:0] HIST_SINGLE = 2'b11;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, READY} state_t;
  // Adds two sign-extended operands and clamps to a w-bit signed range.
  // Result: {saturated, clamped value sign-extended to 32 bits}.
  function automatic logic [32:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
    logic signed [32:0] s, hi, lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    return s > hi ? {1'b1, hi[31:0]} : s < lo ? {1'b1, lo[31:0]} : {1'b0, s[31:0]};
  endfunction
endpackage

// File: rtl/pool_wb_ram.sv
// pool_wb_ram: DEPTH x DW feature-map buffer
//   clk, rst          : clock; rst only clears the external read data register
//   ra_addr/ra_data   : synchronous read port feeding the accumulate pipeline
//   we/wa/wd          : write port
//   rb_en/rb_addr/rb_data : enabled synchronous external read port, data holds when idle
module pool_wb_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          rb_en,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    ra_data <= mem[ra_addr];
  end
  always_ff @(posedge clk) begin
    if (rst) rb_data <= '0;
    else if (rb_en) rb_data <= mem[rb_addr];
  end
endmodule

// File: rtl/pool_writeback.sv
// pool_writeback: captures pooled samples into a feature-map buffer, accumulating across passes with saturation
//   in : clk, rst (sync, active high), pool_valid/pool_data/pool_addr/pool_hist (sample strobe),
//        com_end (pass delivered), rd_en/rd_addr (map read request)
//   out: rd_data/rd_valid (1-cycle read), busy, ready, done (pulse), sat_flag, addr_err (sticky per image)
//   Define POOL_WB_RELU_EN to clamp negative final-pass results (hist 10/11) to zero.
module pool_writeback
  import pool_wb_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pool_valid,
  input  logic [DW-1:0] pool_data,
  input  logic [15:0]   pool_addr,
  input  logic [1:0]    pool_hist,
  input  logic          com_end,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          ready,
  output logic          done,
  output logic          sat_flag,
  output logic          addr_err
);
  state_t state;
  logic [1:0] last_hist, eff_last, s1_hist;
  logic s1_valid, s1_inr, s2_wr, drain_cnt;
  logic [AW-1:0] s1_addr, s2_addr;
  logic signed [DW-1:0] s1_data, s2_val, ra_data, old_val, sum_val, new_val;
  logic [32:0] sa;
  logic idle_like, start_tag, start, accept, in_range, wr, sat_now, accum;
  always_comb begin
    idle_like = state == IDLE || state == READY;
    start_tag = pool_hist == HIST_FIRST || pool_hist == HIST_SINGLE;
    start     = pool_valid && idle_like && start_tag;
    accept    = start || (pool_valid && state == COLLECT);
    in_range  = int'(pool_addr) < DEPTH;
    eff_last  = accept ? pool_hist : last_hist;
    accum     = s1_hist == HIST_MID || s1_hist == HIST_LAST;
    // The buffer read for a sample issued right behind a same-address write is stale; take the write value.
    old_val   = (s2_wr && s2_addr == s1_addr) ? s2_val : ra_data;
    sa        = sat_add(32'(old_val), 32'(s1_data), DW);
    sum_val   = accum ? DW'(sa) : s1_data;
`ifdef POOL_WB_RELU_EN
    new_val   = ((s1_hist == HIST_LAST || s1_hist == HIST_SINGLE) && sum_val[DW-1]) ? '0 : sum_val;
`else
    new_val   = sum_val;
`endif
    wr        = s1_valid && s1_inr && !rst;
    sat_now   = wr && accum && sa[32];
  end
  pool_wb_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .rst(rst),
    .ra_addr(pool_addr[AW-1:0]), .ra_data(ra_data),
    .we(wr), .wa(s1_addr), .wd(new_val),
    .rb_en(rd_en && ready), .rb_addr(rd_addr), .rb_data(rd_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ready     <= 1'b0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
      addr_err  <= 1'b0;
      rd_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      s2_wr     <= 1'b0;
      drain_cnt <= 1'b0;
      last_hist <= HIST_FIRST;
    end else begin
      done     <= 1'b0;
      rd_valid <= rd_en && ready;
      s1_valid <= accept;
      s1_inr   <= in_range;
      s1_addr  <= pool_addr[AW-1:0];
      s1_data  <= pool_data;
      s1_hist  <= pool_hist;
      s2_wr    <= wr;
      s2_addr  <= s1_addr;
      s2_val   <= new_val;
      sat_flag <= (start ? 1'b0 : sat_flag) | sat_now;
      addr_err <= (start ? 1'b0 : addr_err) | (accept && !in_range) | (pool_valid && idle_like && !start_tag);
      if (accept) last_hist <= pool_hist;
      case (state)
        IDLE, READY: if (start) begin
          state <= COLLECT;
          busy  <= 1'b1;
          ready <= 1'b0;
        end
        COLLECT: if (com_end && (eff_last == HIST_LAST || eff_last == HIST_SINGLE)) begin
          state     <= DRAIN;
          drain_cnt <= 1'b0;
        end
        // Two cycles let the last sample clear S1 and S2 before the map is declared readable.
        DRAIN: if (drain_cnt) begin
          state <= READY;
          busy  <= 1'b0;
          ready <= 1'b1;
          done  <= 1'b1;
        end else drain_cnt <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_writeback.sv
// tb_pool_writeback: randomized scoreboard bench for pool_writeback against an array-based map model
module tb_pool_writeback;
  logic clk = 0, rst = 1, pool_valid = 0, com_end = 0, rd_en = 0;
  logic [15:0] pool_data = 0, pool_addr = 0;
  logic [1:0] pool_hist = 0;
  logic [5:0] rd_addr = 0;
  logic [15:0] rd_data;
  logic rd_valid, busy, ready, done, sat_flag, addr_err;
  pool_writeback dut (
    .clk(clk), .rst(rst), .pool_valid(pool_valid), .pool_data(pool_data), .pool_addr(pool_addr),
    .pool_hist(pool_hist), .com_end(com_end), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .ready(ready), .done(done), .sat_flag(sat_flag), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  int checks = 0, passes = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int model[64];
  bit collecting = 0, m_sat = 0, m_err = 0, m_ready = 0, pend_done = 0;
  logic [1:0] last_tag = 0;
  int exp_q[$], cyc_q[$];
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_end();
    if (collecting && (last_tag == 2 || last_tag == 3)) begin
      collecting = 0;
      pend_done = 1;
    end
  endtask
  // Model: first/single passes overwrite, middle/last passes add with clamping to 16-bit signed.
  task automatic send(input int d, input int a, input logic [1:0] h, input bit ce);
    int v;
    pool_valid = 1; pool_data = 16'(d); pool_addr = 16'(a); pool_hist = h; com_end = ce;
    if (!collecting && (h == 1 || h == 2)) m_err = 1;
    else begin
      if (!collecting) begin collecting = 1; m_sat = 0; m_err = 0; m_ready = 0; end
      last_tag = h;
      if (a >= 64) m_err = 1;
      else begin
        v = (h == 0 || h == 3) ? d : model[a] + d;
        if (v > 32767) begin v = 32767; m_sat = 1; end
        if (v < -32768) begin v = -32768; m_sat = 1; end
`ifdef POOL_WB_RELU_EN
        if ((h == 2 || h == 3) && v < 0) v = 0;
`endif
        model[a] = v;
      end
    end
    if (ce) model_end();
    tick();
    pool_valid = 0; com_end = 0;
  endtask
  task automatic settle();
    int n = 0;
    if (pend_done) begin
      while (!done && n < 10) begin tick(); n++; end
      check("done_latency", n + 1, 3);
      tick();
      check("done_pulse", done, 0);
      check("ready", ready, 1);
      check("busy", busy, 0);
      check("sat_flag", sat_flag, m_sat);
      check("addr_err", addr_err, m_err);
      pend_done = 0;
      m_ready = 1;
    end else begin
      tick();
      check("busy_mid", busy, 1);
      check("done_mid", done, 0);
    end
  endtask
  task automatic end_pass();
    com_end = 1;
    model_end();
    tick();
    com_end = 0;
    settle();
  endtask
  task automatic rd(input int a);
    rd_en = 1; rd_addr = 6'(a);
    if (m_ready) begin exp_q.push_back(model[a]); cyc_q.push_back(cyc); end
    tick();
    rd_en = 0;
    if (!m_ready) check("rd_ignored", rd_valid, 0);
  endtask
  task automatic rand_image();
    int np, ns, a, d;
    logic [1:0] h;
    bit ce;
    np = $urandom_range(1, 3);
    for (int p = 0; p < np; p++) begin
      h = np == 1 ? 2'd3 : p == 0 ? 2'd0 : p == np - 1 ? 2'd2 : 2'd1;
      ns = $urandom_range(3, 20);
      ce = 0;
      for (int i = 0; i < ns; i++) begin
        a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(64, 90)) : int'($urandom_range(0, 63));
        d = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 400)) - 200;
        ce = (i == ns - 1) && $urandom_range(0, 1) == 1;
        send(d, a, h, ce);
        if (i < ns - 1 && $urandom_range(0, 4) == 0) tick();
      end
      if (ce) settle(); else end_pass();
    end
    for (int i = 0; i < 8; i++) rd($urandom_range(0, 63));
  endtask
  initial begin
    int e, c;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("rd_data", int'($signed(rd_data)), e);
          check("rd_latency", cyc - c, 1);
        end
      end
    end
  end
  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_err", addr_err, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 0;
    tick();
    rd(3);
    for (int a = 0; a < 64; a++) send(a * 3, a, 2'd3, 0);
    end_pass();
    for (int a = 0; a < 64; a++) rd(a);
    rd_en = 1; rd_addr = 0;
    exp_q.push_back(model[0]); cyc_q.push_back(cyc);
    send(100, 0, 2'd0, 0);
    rd_en = 0;
    check("ready_drop", ready, 0);
    for (int a = 1; a < 64; a++) send(100, a, 2'd0, 0);
    end_pass();
    for (int a = 0; a < 64; a++) send(-30, a, 2'd1, 0);
    end_pass();
    for (int a = 0; a < 64; a++) send(5, a, 2'd2, 0);
    end_pass();
    for (int i = 0; i < 16; i++) rd($urandom_range(0, 63));
    send(32000, 5, 2'd0, 0);
    end_pass();
    send(1000, 5, 2'd2, 1);
    settle();
    rd(5);
    send(-32000, 5, 2'd0, 0);
    end_pass();
    send(-1000, 5, 2'd2, 1);
    settle();
    rd(5);
    send(10, 7, 2'd0, 0);
    send(20, 7, 2'd1, 0);
    send(30, 7, 2'd2, 0);
    end_pass();
    rd(7);
    send(1, 3, 2'd3, 0);
    send(9, 70, 2'd3, 0);
    rd(3);
    end_pass();
    rd(3);
    send(5, 4, 2'd1, 0);
    check("drop_err", addr_err, 1);
    check("drop_ready", ready, 1);
    rd(4);
    send(50, 9, 2'd0, 0);
    end_pass();
    send(-100, 9, 2'd2, 0);
    end_pass();
    rd(9);
    for (int i = 0; i < 25; i++) rand_image();
    send(1, 1, 2'd3, 0);
    send(2, 2, 2'd3, 0);
    rst = 1;
    collecting = 0; m_ready = 0;
    tick();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", ready, 0);
    rst = 0;
    repeat (4) tick();
    check("rst_mid_done", done, 0);
    check("rst_mid_idle", busy, 0);
    repeat (3) tick();
    check("rd_pending", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
